// File: rtl/riscv_pkg.sv
// Shared RV32 fetch constants: NOP encoding, flush depth, opcodes, fetch FSM states
// and the operand-usage helpers used by the register-address decode.
package riscv_pkg;

    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned FLUSH_CNT_W  = 2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StHold  = 2'd1,
        StFlush = 2'd2
    } fetch_state_e;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return opc inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
    endfunction

    function automatic logic uses_rd(input logic [6:0] opc);
        return opc inside {OPC_OP, OPC_OP_IMM, OPC_JALR, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory fetch bus between fetch_ctrl (master) and the memory (slave).
interface fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (output imem_addr, output imem_req, input imem_rdata, input imem_valid);
    modport slave  (input imem_addr, input imem_req, output imem_rdata, output imem_valid);
endinterface

// File: rtl/pipeline_latch.sv
// Generic pipeline register with hold (stall) and asynchronous active-low reset.
module pipeline_latch #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, hold/squash/flush handling, IF latch.
// Optional FETCH_PERF_CNT_EN adds saturating HOLD/FLUSH cycle counters.
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump_taken,
    input  logic [31:0]         jump_target,
    input  logic                control_hazard,
    input  logic                data_hazard,
    input  logic                stall,
    fetch_ctrl_if.master        imem,
    output logic [31:0]         if_instr,
    output logic [31:0]         if_pc,
    output logic                if_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]         hold_cycles,
    output logic [31:0]         flush_cycles,
`endif
    output logic [4:0]          a0,
    output logic [4:0]          a1,
    output logic [4:0]          a2
);

    fetch_state_e           state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
    logic                   squash, hold, fetch;
    logic [31:0]            instr_d;
    logic [6:0]             opc;

    // control_hazard is meaningless while already flushing a redirect
    assign squash = control_hazard && (state_q != StFlush);
    assign hold   = !jump_taken && !squash && (data_hazard || stall);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        fetch   = 1'b0;
        if (jump_taken) begin
            pc_d    = jump_target;
            cnt_d   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
            state_d = StFlush;
        end else if (squash) begin
            state_d = StRun;
        end else if (hold) begin
            state_d = StHold;
        end else begin
            unique case (state_q)
                // last flush edge already captures the word at the redirect target
                StFlush: begin
                    if (cnt_q == '0) begin
                        state_d = StRun;
                        fetch   = imem.imem_valid;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                // no request was issued while holding, so leaving HOLD is a bubble
                StHold:  state_d = StRun;
                default: fetch   = imem.imem_valid;
            endcase
        end
        if (fetch) pc_d = pc_q + 32'd4;
    end

    assign instr_d = fetch ? imem.imem_rdata : NOP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    pipeline_latch #(.WIDTH(32), .RESET_VAL(NOP)) u_instr_latch (
        .clk   (clk),
        .rst   (rst),
        .stall (hold),
        .d     (instr_d),
        .q     (if_instr)
    );

    pipeline_latch #(.WIDTH(32), .RESET_VAL(32'h0)) u_pc_latch (
        .clk   (clk),
        .rst   (rst),
        .stall (hold),
        .d     (pc_q),
        .q     (if_pc)
    );

    pipeline_latch #(.WIDTH(1), .RESET_VAL(1'b0)) u_valid_latch (
        .clk   (clk),
        .rst   (rst),
        .stall (hold),
        .d     (fetch),
        .q     (if_valid)
    );

    assign imem.imem_addr = pc_q;
    assign imem.imem_req  = rst && (state_q != StHold);

    assign opc = if_instr[6:0];

    always_comb begin
        a0 = '0;
        a1 = '0;
        a2 = '0;
        if (if_valid) begin
            if (uses_rs1(opc)) a0 = if_instr[19:15];
            if (uses_rs2(opc)) a1 = if_instr[24:20];
            if (uses_rd(opc))  a2 = if_instr[11:7];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cycles  <= '0;
            flush_cycles <= '0;
        end else begin
            if (state_q == StHold && hold_cycles != '1)   hold_cycles  <= hold_cycles + 32'd1;
            if (state_q == StFlush && flush_cycles != '1) flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif

endmodule
